ls_queue: RTL and testbench
===========================

# ls_queue

In-order load/store queue that sits directly upstream of the load/store functional unit. It buffers memory instructions from dispatch and captures their operands from the CDB. It presents the oldest eligible instruction to the unit and holds it stable until the unit reports `done`. Stores issue only after the ROB commits them; loads issue as soon as their base operand is ready.

## Interface
- `DEPTH`, 8, number of entries (power of two, ≥2)
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low; `reset==0` at a rising edge clears the block
- `enq_valid`  in  1  dispatch writes one entry this cycle
- `enq_read_write`  in  1  1=load, 0=store
- `enq_func3`  in  3  width/sign code, passed through
- `enq_imm`  in  `XLEN`  address offset
- `enq_tag`  in  `ROB_TAG_LEN`  ROB tag of instruction
- `enq_src1_ready`, `enq_src2_ready`  in  1 each  operand already valid
- `enq_src1_value`, `enq_src2_value`  in  `XLEN` each  operand values (src1=base, src2=store data)
- `enq_src1_tag`, `enq_src2_tag`  in  `ROB_TAG_LEN` each  producer tags when not ready
- `enq_ready`  out  1  queue can accept (`count < DEPTH`)
- `cdb_valid`  in  1  CDB broadcast valid
- `cdb_tag`  in  `ROB_TAG_LEN`;  `cdb_value`  in  `XLEN`
- `commit_valid`  in  1;  `commit_tag`  in  `ROB_TAG_LEN`  ROB head retiring
- `flush`  in  1  mispredict squash
- `issue_en`  out  1  drives unit `en`
- `issue_read_write`, `issue_func3`, `issue_value_src1`, `issue_value_src2`, `issue_imm`, `issue_tag`  out  1/3/`XLEN`/`XLEN`/`XLEN`/`ROB_TAG_LEN`  head entry fields
- `unit_done`  in  1  unit completed the presented op
- `count`  out  `$clog2(DEPTH+1)`  occupied entries

## Operation
- Circular buffer with head/tail pointers of width `$clog2(DEPTH)`. Pointers wrap modulo DEPTH. Entry fields: valid, read_write, func3, imm, tag, src1/src2 ready+value+tag, committed.
- Enqueue: accepted iff `enq_valid && enq_ready`; written at tail; committed=0. If `cdb_valid` matches a not-ready enq src tag in the same cycle, that src is written ready with `cdb_value`.
- Wakeup: every valid entry with srcX not ready and srcX tag == `cdb_tag` (`cdb_valid`=1) captures value and sets ready. Stores need src2; loads ignore src2 readiness.
- Commit: every valid store entry with tag == `commit_tag` (`commit_valid`=1) sets committed.
- Head eligible: valid && src1 ready && (load || (src2 ready && committed)).
- FSM:
  - IDLE: `issue_en=0`. If the head is eligible (registered state), go to BUSY.
  - BUSY: `issue_en=1`; outputs show the head fields and stay stable. On `unit_done=1`, pop the head. Go to BUSY if the entry at head+1 is eligible, else IDLE. On `unit_done=0` (miss), remain in BUSY.
- Flush:
  - Removes all entries that are not committed stores. Committed stores are contiguous from the head and are retained.
  - Tail is set to head + retained count.
  - If BUSY on a dropped entry → IDLE. If BUSY on a committed store → remains BUSY.
  - An enqueue in the flush cycle is discarded.
  - Flush has priority over commit and wakeup for dropped entries.
- Simultaneous enqueue and pop: both take effect; count unchanged. When full, `enq_ready=0` even if a pop occurs that cycle.

## Timing
- Reset values: all entries invalid, head=tail=0, state IDLE, `count=0`, `enq_ready=1`, `issue_en=0`, all issue_* = 0. Reset mid-BUSY abandons the op.
- Enqueue at edge E → entry visible E+1. If it is already eligible, `issue_en=1` from cycle E+2.
- CDB or commit at edge C → eligible C+1 → `issue_en` C+2.
- Pop occurs at the edge where `unit_done=1`. Back-to-back issue: the next eligible entry keeps `issue_en=1` with new fields on the following cycle. Sustained throughput is 1 op/cycle on hits.
- `count`, `enq_ready`, and issue_* are registered and carry no combinational path from inputs.

## Test plan
- Reset: hold `reset=0` for 2 cycles mid-traffic → `count=0`, `issue_en=0`, `enq_ready=1`.
- Ready load: enq load tag 3, src1=0x100, imm=0x4 at cycle 0 → `issue_en=1` at cycle 2 with src1 0x100, imm 0x4, read_write=1. Hold `unit_done=0` 3 cycles → fields stable. Then `unit_done=1` → `count=0`.
- Store gating: enq store tag 5, both srcs ready → `issue_en` stays 0 for 10 cycles. Commit tag 5 at cycle C → `issue_en=1` at C+2 with src2 value.
- Wakeup: load src1 tag 7 not ready. CDB tag 7 value 0x2000 → issue with `issue_value_src1=0x2000`. Same-cycle enq+CDB bypass gives the same result.
- Full/wrap: 8 enqueues → `enq_ready=0`, `count=8`. A 9th is ignored. Pop 3, enqueue 3 (wrap) → FIFO order is preserved.
- Flush: committed store tag 1 at head (BUSY), loads tags 2 and 3 behind. Flush → `count=1`, `issue_en` stays 1 for tag 1. `unit_done` → `count=0`, IDLE.

Source files
------------

// File: rtl/ls_queue.sv
// In-order load/store queue feeding the load/store unit. Buffers dispatched
// memory ops, captures operands from the CDB, marks stores committed by the
// ROB, and presents the oldest eligible op until the unit reports done.
module ls_queue #(
  parameter int DEPTH       = 8,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enq_valid,
  input  logic                         enq_read_write,
  input  logic [2:0]                   enq_func3,
  input  logic [XLEN-1:0]              enq_imm,
  input  logic [ROB_TAG_LEN-1:0]       enq_tag,
  input  logic                         enq_src1_ready,
  input  logic                         enq_src2_ready,
  input  logic [XLEN-1:0]              enq_src1_value,
  input  logic [XLEN-1:0]              enq_src2_value,
  input  logic [ROB_TAG_LEN-1:0]       enq_src1_tag,
  input  logic [ROB_TAG_LEN-1:0]       enq_src2_tag,
  output logic                         enq_ready,
  input  logic                         cdb_valid,
  input  logic [ROB_TAG_LEN-1:0]       cdb_tag,
  input  logic [XLEN-1:0]              cdb_value,
  input  logic                         commit_valid,
  input  logic [ROB_TAG_LEN-1:0]       commit_tag,
  input  logic                         flush,
  output logic                         issue_en,
  output logic                         issue_read_write,
  output logic [2:0]                   issue_func3,
  output logic [XLEN-1:0]              issue_value_src1,
  output logic [XLEN-1:0]              issue_value_src2,
  output logic [XLEN-1:0]              issue_imm,
  output logic [ROB_TAG_LEN-1:0]       issue_tag,
  input  logic                         unit_done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic                   valid;
    logic                   rw;
    logic [2:0]             func3;
    logic [XLEN-1:0]        imm;
    logic [ROB_TAG_LEN-1:0] tag;
    logic                   s1_rdy;
    logic [XLEN-1:0]        s1_val;
    logic [ROB_TAG_LEN-1:0] s1_tag;
    logic                   s2_rdy;
    logic [XLEN-1:0]        s2_val;
    logic [ROB_TAG_LEN-1:0] s2_tag;
    logic                   committed;
  } ent_t;

  typedef enum logic {IDLE, BUSY} state_t;

  ent_t                   ent_q [DEPTH];
  logic [PW-1:0]          head_q, tail_q, head_n1;
  logic [CW-1:0]          count_q, count_d, nkeep;
  logic                   enq_ready_q;
  state_t                 state_q;
  logic                   iss_en_q, iss_rw_q;
  logic [2:0]             iss_f3_q;
  logic [XLEN-1:0]        iss_s1_q, iss_s2_q, iss_imm_q;
  logic [ROB_TAG_LEN-1:0] iss_tag_q;

  logic [DEPTH-1:0]       elig, keep;
  logic                   run, enq_acc, pop, byp1, byp2;
  logic [PW-1:0]          idx;
  ent_t                   enq_ent;

  assign head_n1 = head_q + PW'(1);
  assign enq_acc = enq_valid && enq_ready_q && !flush;
  // A flush only cancels the in-flight op when it is not a retained store.
  assign pop     = (state_q == BUSY) && unit_done && (!flush || keep[head_q]);

  // Per-entry issue eligibility from registered state.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++)
      elig[i] = ent_q[i].valid && ent_q[i].s1_rdy &&
                (ent_q[i].rw || (ent_q[i].s2_rdy && ent_q[i].committed));
  end

  // Committed stores contiguous from head survive a flush.
  always_comb begin
    keep  = '0;
    nkeep = '0;
    run   = 1'b1;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (run && ent_q[idx].valid && !ent_q[idx].rw && ent_q[idx].committed) begin
        keep[idx] = 1'b1;
        nkeep     = nkeep + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // New entry with same-cycle CDB bypass on not-ready sources.
  always_comb begin
    byp1              = !enq_src1_ready && cdb_valid && (cdb_tag == enq_src1_tag);
    byp2              = !enq_src2_ready && cdb_valid && (cdb_tag == enq_src2_tag);
    enq_ent           = '0;
    enq_ent.valid     = 1'b1;
    enq_ent.rw        = enq_read_write;
    enq_ent.func3     = enq_func3;
    enq_ent.imm       = enq_imm;
    enq_ent.tag       = enq_tag;
    enq_ent.s1_rdy    = enq_src1_ready || byp1;
    enq_ent.s1_val    = byp1 ? cdb_value : enq_src1_value;
    enq_ent.s1_tag    = enq_src1_tag;
    enq_ent.s2_rdy    = enq_src2_ready || byp2;
    enq_ent.s2_val    = byp2 ? cdb_value : enq_src2_value;
    enq_ent.s2_tag    = enq_src2_tag;
    enq_ent.committed = 1'b0;
  end

  // Occupancy after this cycle's enqueue, pop and flush.
  always_comb begin
    if (flush) count_d = nkeep - CW'(pop);
    else       count_d = count_q + CW'(enq_acc) - CW'(pop);
  end

  // Entry storage: wakeup, commit, flush drop, pop and enqueue.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].valid) begin
          if (cdb_valid && !ent_q[i].s1_rdy && ent_q[i].s1_tag == cdb_tag) begin
            ent_q[i].s1_rdy <= 1'b1;
            ent_q[i].s1_val <= cdb_value;
          end
          if (cdb_valid && !ent_q[i].s2_rdy && ent_q[i].s2_tag == cdb_tag) begin
            ent_q[i].s2_rdy <= 1'b1;
            ent_q[i].s2_val <= cdb_value;
          end
          if (commit_valid && !ent_q[i].rw && ent_q[i].tag == commit_tag)
            ent_q[i].committed <= 1'b1;
        end
        if (flush && !keep[i]) ent_q[i].valid <= 1'b0;
      end
      if (pop)     ent_q[head_q].valid <= 1'b0;
      if (enq_acc) ent_q[tail_q]       <= enq_ent;
    end
  end

  // Pointers, count and full flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      enq_ready_q <= 1'b1;
    end else begin
      if (pop) head_q <= head_n1;
      if (flush)        tail_q <= head_q + PW'(nkeep);
      else if (enq_acc) tail_q <= tail_q + PW'(1);
      count_q     <= count_d;
      enq_ready_q <= (count_d < CW'(DEPTH));
    end
  end

  // Issue FSM with registered outputs latched from the presented entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      iss_en_q  <= 1'b0;
      iss_rw_q  <= 1'b0;
      iss_f3_q  <= '0;
      iss_s1_q  <= '0;
      iss_s2_q  <= '0;
      iss_imm_q <= '0;
      iss_tag_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig[head_q] && (!flush || keep[head_q])) begin
            state_q   <= BUSY;
            iss_en_q  <= 1'b1;
            iss_rw_q  <= ent_q[head_q].rw;
            iss_f3_q  <= ent_q[head_q].func3;
            iss_s1_q  <= ent_q[head_q].s1_val;
            iss_s2_q  <= ent_q[head_q].s2_val;
            iss_imm_q <= ent_q[head_q].imm;
            iss_tag_q <= ent_q[head_q].tag;
          end
        end
        BUSY: begin
          if (flush && !keep[head_q]) begin
            state_q  <= IDLE;
            iss_en_q <= 1'b0;
          end else if (unit_done) begin
            if (elig[head_n1] && (!flush || keep[head_n1])) begin
              iss_rw_q  <= ent_q[head_n1].rw;
              iss_f3_q  <= ent_q[head_n1].func3;
              iss_s1_q  <= ent_q[head_n1].s1_val;
              iss_s2_q  <= ent_q[head_n1].s2_val;
              iss_imm_q <= ent_q[head_n1].imm;
              iss_tag_q <= ent_q[head_n1].tag;
            end else begin
              state_q  <= IDLE;
              iss_en_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          iss_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign enq_ready        = enq_ready_q;
  assign count            = count_q;
  assign issue_en         = iss_en_q;
  assign issue_read_write = iss_rw_q;
  assign issue_func3      = iss_f3_q;
  assign issue_value_src1 = iss_s1_q;
  assign issue_value_src2 = iss_s2_q;
  assign issue_imm        = iss_imm_q;
  assign issue_tag        = iss_tag_q;
endmodule

// File: tb/tb_ls_queue.sv
// Scoreboard bench for ls_queue: expected issue records are queued at
// enqueue time and compared whenever the unit accepts an op.
module tb_ls_queue;
  localparam int DEPTH = 8, XLEN = 32, TL = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            enq_valid, enq_read_write, enq_src1_ready, enq_src2_ready;
  logic [2:0]      enq_func3;
  logic [XLEN-1:0] enq_imm, enq_src1_value, enq_src2_value;
  logic [TL-1:0]   enq_tag, enq_src1_tag, enq_src2_tag;
  logic            enq_ready;
  logic            cdb_valid;
  logic [TL-1:0]   cdb_tag;
  logic [XLEN-1:0] cdb_value;
  logic            commit_valid;
  logic [TL-1:0]   commit_tag;
  logic            flush;
  logic            issue_en, issue_read_write;
  logic [2:0]      issue_func3;
  logic [XLEN-1:0] issue_value_src1, issue_value_src2, issue_imm;
  logic [TL-1:0]   issue_tag;
  logic            unit_done;
  logic [3:0]      count;

  typedef struct {
    logic            rw;
    logic [2:0]      f3;
    logic [XLEN-1:0] s1, s2, imm;
    logic [TL-1:0]   tag;
  } exp_t;
  exp_t sb[$];

  int nchk = 0, nerr = 0;

  ls_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_TAG_LEN(TL)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_read_write(enq_read_write), .enq_func3(enq_func3),
    .enq_imm(enq_imm), .enq_tag(enq_tag),
    .enq_src1_ready(enq_src1_ready), .enq_src2_ready(enq_src2_ready),
    .enq_src1_value(enq_src1_value), .enq_src2_value(enq_src2_value),
    .enq_src1_tag(enq_src1_tag), .enq_src2_tag(enq_src2_tag),
    .enq_ready(enq_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
    .issue_en(issue_en), .issue_read_write(issue_read_write), .issue_func3(issue_func3),
    .issue_value_src1(issue_value_src1), .issue_value_src2(issue_value_src2),
    .issue_imm(issue_imm), .issue_tag(issue_tag),
    .unit_done(unit_done), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; an op accepted at this edge is scored first.
  task automatic cyc();
    exp_t e;
    if (reset && issue_en && unit_done) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("iss_tag", issue_tag, e.tag);
        chk("iss_rw", issue_read_write, e.rw);
        chk("iss_f3", issue_func3, e.f3);
        chk("iss_s1", issue_value_src1, e.s1);
        chk("iss_s2", issue_value_src2, e.s2);
        chk("iss_imm", issue_imm, e.imm);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic enq(input logic rw, input logic [TL-1:0] tag, input logic s1r,
                     input logic [XLEN-1:0] s1v, input logic [TL-1:0] s1t,
                     input logic [XLEN-1:0] s2v, input logic [XLEN-1:0] imm,
                     input logic [2:0] f3, input logic [XLEN-1:0] exp_s1, input bit push);
    exp_t e;
    enq_valid = 1; enq_read_write = rw; enq_tag = tag; enq_src1_ready = s1r;
    enq_src1_value = s1v; enq_src1_tag = s1t; enq_src2_ready = 1;
    enq_src2_value = s2v; enq_src2_tag = 0; enq_imm = imm; enq_func3 = f3;
    if (push) begin
      e.rw = rw; e.f3 = f3; e.s1 = exp_s1; e.s2 = s2v; e.imm = imm; e.tag = tag;
      sb.push_back(e);
    end
    cyc();
    enq_valid = 0;
  endtask

  task automatic wait_issue(input int max);
    int n = 0;
    while (!issue_en && n < max) begin cyc(); n++; end
    chk("wait_issue", issue_en, 1);
  endtask

  initial begin
    reset = 0; enq_valid = 0; enq_read_write = 0; enq_func3 = 0; enq_imm = 0;
    enq_tag = 0; enq_src1_ready = 0; enq_src2_ready = 0; enq_src1_value = 0;
    enq_src2_value = 0; enq_src1_tag = 0; enq_src2_tag = 0; cdb_valid = 0;
    cdb_tag = 0; cdb_value = 0; commit_valid = 0; commit_tag = 0; flush = 0;
    unit_done = 0;
    cyc(); cyc(); reset = 1;
    chk("rst_count", count, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_issue_en", issue_en, 0);
    chk("rst_issue_tag", issue_tag, 0);

    // Ready load: issue two cycles after enqueue, hold while done is low.
    enq(1, 3, 1, 32'h100, 0, 0, 32'h4, 3'd2, 32'h100, 1);
    chk("load_c1_en", issue_en, 0);
    cyc();
    chk("load_c2_en", issue_en, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_en", issue_en, 1);
      chk("hold_s1", issue_value_src1, 32'h100);
      chk("hold_imm", issue_imm, 32'h4);
      chk("hold_rw", issue_read_write, 1);
    end
    unit_done = 1; cyc(); unit_done = 0;
    chk("load_count", count, 0);
    chk("load_idle", issue_en, 0);

    // Store waits for commit.
    enq(0, 5, 1, 32'h10, 0, 32'hAB, 32'h8, 3'd0, 32'h10, 1);
    for (int i = 0; i < 10; i++) begin cyc(); chk("st_gated", issue_en, 0); end
    commit_valid = 1; commit_tag = 5; cyc(); commit_valid = 0;
    chk("st_c1_en", issue_en, 0);
    cyc();
    chk("st_c2_en", issue_en, 1);
    chk("st_s2", issue_value_src2, 32'hAB);
    unit_done = 1; cyc(); unit_done = 0;

    // Wakeup via CDB after enqueue.
    enq(1, 8, 0, 32'h0, 7, 0, 32'h0, 3'd1, 32'h2000, 1);
    cyc(); chk("wk_wait", issue_en, 0);
    cdb_valid = 1; cdb_tag = 7; cdb_value = 32'h2000; cyc(); cdb_valid = 0;
    chk("wk_c1_en", issue_en, 0);
    wait_issue(4);
    unit_done = 1; cyc(); unit_done = 0;

    // Wakeup via same-cycle bypass.
    cdb_valid = 1; cdb_tag = 7; cdb_value = 32'h2000;
    enq(1, 9, 0, 32'h0, 7, 0, 32'h0, 3'd1, 32'h2000, 1);
    cdb_valid = 0;
    wait_issue(4);
    unit_done = 1; cyc(); unit_done = 0;
    chk("wk_count", count, 0);

    // Fill, overflow attempt, partial drain, wrap refill, full drain.
    for (int i = 0; i < 8; i++)
      enq(1, TL'(10 + i), 1, 32'(i * 32'h11), 0, 0, 32'(i), 3'(i), 32'(i * 32'h11), 1);
    chk("full_count", count, 8);
    chk("full_ready", enq_ready, 0);
    enq(1, 30, 1, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    chk("ovf_count", count, 8);
    unit_done = 1;
    for (int i = 0; i < 3; i++) cyc();
    unit_done = 0;
    chk("pop3_count", count, 5);
    chk("pop3_ready", enq_ready, 1);
    for (int i = 0; i < 3; i++)
      enq(1, TL'(18 + i), 1, 32'(32'h900 + i), 0, 0, 32'(i), 3'd4, 32'(32'h900 + i), 1);
    chk("wrap_count", count, 8);
    unit_done = 1;
    for (int n = 0; n < 40 && count != 0; n++) cyc();
    unit_done = 0;
    chk("drain_count", count, 0);
    chk("sb_drained", sb.size(), 0);

    // Flush keeps the committed store at head and drops the loads behind it.
    enq(0, 1, 1, 32'h40, 0, 32'h55, 32'h0, 3'd2, 32'h40, 1);
    commit_valid = 1; commit_tag = 1;
    enq(1, 2, 1, 32'h50, 0, 0, 32'h0, 3'd2, 32'h50, 1);
    commit_valid = 0;
    enq(1, 3, 1, 32'h60, 0, 0, 32'h0, 3'd2, 32'h60, 1);
    wait_issue(5);
    chk("fl_pre_tag", issue_tag, 1);
    flush = 1; cyc(); flush = 0;
    void'(sb.pop_back()); void'(sb.pop_back());
    chk("fl_count", count, 1);
    chk("fl_en", issue_en, 1);
    chk("fl_tag", issue_tag, 1);
    unit_done = 1; cyc(); unit_done = 0;
    chk("fl_done_count", count, 0);
    chk("fl_done_en", issue_en, 0);
    cyc(); cyc();
    chk("fl_stay_idle", issue_en, 0);

    // Reset in the middle of a busy op.
    enq(1, 12, 1, 32'h77, 0, 0, 32'h0, 3'd0, 32'h77, 1);
    enq(1, 13, 1, 32'h78, 0, 0, 32'h0, 3'd0, 32'h78, 1);
    wait_issue(4);
    reset = 0; cyc(); cyc(); reset = 1;
    sb.delete();
    chk("mrst_count", count, 0);
    chk("mrst_en", issue_en, 0);
    chk("mrst_ready", enq_ready, 1);
    cyc(); cyc();
    chk("mrst_idle", issue_en, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
